// File: rtl/thermostat_frame_check.sv
// Validates decoded thermostat frames, keeps good/bad counters, converts room temperature to
// BCD with an iterative double-dabble and time-multiplexes the digits for a 7-segment decoder.
module thermostat_frame_check #(
  parameter logic [31:0] EXPECTED_PREAMBLE = 32'h5555_5555,
  parameter logic [31:0] EXPECTED_CONSTANT = 32'h0000_0000,
  parameter int unsigned DIGIT_HOLD        = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_strobe,
  input  logic [31:0] preamble,
  input  logic [31:0] constant,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        have_frame,
  output logic        overrun,
  output logic        clamped,
  output logic [7:0]  good_count,
  output logic [7:0]  bad_count,
  output logic [31:0] id_out,
  output logic [15:0] set_temp_out,
  output logic [7:0]  state_out,
  output logic [11:0] room_bcd,
  output logic        bcd_ready,
  output logic [3:0]  digit,
  output logic [1:0]  digit_place
);

  localparam int unsigned HoldW = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;

  typedef enum logic [1:0] {StIdle, StCheck, StConvert} state_e;

  state_e state_q, state_d;
  logic   snap, do_ok, do_err, iter, finish, drop;

  logic [31:0] sh_pre_q, sh_con_q, sh_id_q;
  logic [15:0] sh_room_q, sh_set_q;
  logic [7:0]  sh_state_q;

  logic [9:0]  conv_bin_q;
  logic [11:0] conv_bcd_q;
  logic [3:0]  conv_cnt_q;
  logic [3:0]  ones_adj, tens_adj;
  logic [9:0]  room_sat;

  logic        frame_ok_q, frame_err_q, have_frame_q, overrun_q, clamped_q, bcd_ready_q;
  logic [7:0]  good_count_q, bad_count_q, state_out_q;
  logic [31:0] id_out_q;
  logic [15:0] set_temp_out_q;
  logic [11:0] room_bcd_q;
  logic [HoldW-1:0] hold_q;
  logic [1:0]  place_q;
  logic [3:0]  digit_sel;

  function automatic logic [3:0] dab_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Hundreds never reaches 5 before a shift because the converted value is at most 999.
  assign ones_adj = dab_adjust(conv_bcd_q[3:0]);
  assign tens_adj = dab_adjust(conv_bcd_q[7:4]);
  assign room_sat = (sh_room_q > 16'd999) ? 10'd999 : sh_room_q[9:0];

  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    do_ok   = 1'b0;
    do_err  = 1'b0;
    iter    = 1'b0;
    finish  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_strobe) begin
          snap    = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        drop = frame_strobe;
        if (sh_pre_q == EXPECTED_PREAMBLE && sh_con_q == EXPECTED_CONSTANT) begin
          do_ok   = 1'b1;
          state_d = StConvert;
        end else begin
          do_err  = 1'b1;
          state_d = StIdle;
        end
      end
      StConvert: begin
        if (conv_cnt_q == 4'd10) begin
          // The result lands this edge, so a new frame may be taken at the same time.
          finish  = 1'b1;
          state_d = StIdle;
          if (frame_strobe) begin
            snap    = 1'b1;
            state_d = StCheck;
          end
        end else begin
          iter = 1'b1;
          drop = frame_strobe;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      sh_pre_q       <= '0;
      sh_con_q       <= '0;
      sh_id_q        <= '0;
      sh_room_q      <= '0;
      sh_set_q       <= '0;
      sh_state_q     <= '0;
      conv_bin_q     <= '0;
      conv_bcd_q     <= '0;
      conv_cnt_q     <= '0;
      frame_ok_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      have_frame_q   <= 1'b0;
      overrun_q      <= 1'b0;
      clamped_q      <= 1'b0;
      bcd_ready_q    <= 1'b0;
      good_count_q   <= '0;
      bad_count_q    <= '0;
      id_out_q       <= '0;
      set_temp_out_q <= '0;
      state_out_q    <= '0;
      room_bcd_q     <= '0;
    end else begin
      state_q     <= state_d;
      frame_ok_q  <= do_ok;
      frame_err_q <= do_err;
      bcd_ready_q <= finish;
      if (snap) begin
        sh_pre_q   <= preamble;
        sh_con_q   <= constant;
        sh_id_q    <= thermostat_id;
        sh_room_q  <= room_temp;
        sh_set_q   <= set_temp;
        sh_state_q <= state;
      end
      if (drop) overrun_q <= 1'b1;
      if (do_ok) begin
        if (good_count_q != 8'hFF) good_count_q <= good_count_q + 8'd1;
        id_out_q       <= sh_id_q;
        set_temp_out_q <= sh_set_q;
        state_out_q    <= sh_state_q;
        clamped_q      <= (sh_room_q > 16'd999);
        conv_bin_q     <= room_sat;
        conv_bcd_q     <= '0;
        conv_cnt_q     <= '0;
      end
      if (do_err && bad_count_q != 8'hFF) bad_count_q <= bad_count_q + 8'd1;
      if (iter) begin
        conv_bcd_q <= {conv_bcd_q[10:8], tens_adj, ones_adj, conv_bin_q[9]};
        conv_bin_q <= {conv_bin_q[8:0], 1'b0};
        conv_cnt_q <= conv_cnt_q + 4'd1;
      end
      if (finish) begin
        room_bcd_q   <= conv_bcd_q;
        have_frame_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      place_q <= 2'd0;
    end else if (hold_q == HoldW'(DIGIT_HOLD - 1)) begin
      hold_q  <= '0;
      place_q <= (place_q == 2'd2) ? 2'd0 : place_q + 2'd1;
    end else begin
      hold_q <= hold_q + 1'b1;
    end
  end

  always_comb begin
    digit_sel = 4'hF;
    if (have_frame_q) begin
      case (place_q)
        2'd0:    digit_sel = room_bcd_q[3:0];
        2'd1:    digit_sel = room_bcd_q[7:4];
        default: digit_sel = room_bcd_q[11:8];
      endcase
    end
  end

  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign have_frame   = have_frame_q;
  assign overrun      = overrun_q;
  assign clamped      = clamped_q;
  assign good_count   = good_count_q;
  assign bad_count    = bad_count_q;
  assign id_out       = id_out_q;
  assign set_temp_out = set_temp_out_q;
  assign state_out    = state_out_q;
  assign room_bcd     = room_bcd_q;
  assign bcd_ready    = bcd_ready_q;
  assign digit        = digit_sel;
  assign digit_place  = place_q;

endmodule

// File: tb/tb_thermostat_frame_check.sv
// Bench for thermostat_frame_check: event-schedule reference model compared every cycle,
// directed scenarios with literal expectations, then randomized frame traffic.
module tb_thermostat_frame_check;

  localparam int unsigned Hold = 4;
  localparam logic [31:0] Pre  = 32'h5555_5555;
  localparam logic [31:0] Con  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_strobe = 1'b0;
  logic [31:0] preamble = '0, constant = '0, thermostat_id = '0;
  logic [15:0] room_temp = '0, set_temp = '0;
  logic [7:0]  state = '0;
  logic        frame_ok, frame_err, have_frame, overrun, clamped, bcd_ready;
  logic [7:0]  good_count, bad_count, state_out;
  logic [31:0] id_out;
  logic [15:0] set_temp_out;
  logic [11:0] room_bcd;
  logic [3:0]  digit;
  logic [1:0]  digit_place;

  thermostat_frame_check #(
    .EXPECTED_PREAMBLE(Pre),
    .EXPECTED_CONSTANT(Con),
    .DIGIT_HOLD(Hold)
  ) dut (
    .clock(clock), .reset_n(reset_n), .frame_strobe(frame_strobe),
    .preamble(preamble), .constant(constant), .thermostat_id(thermostat_id),
    .room_temp(room_temp), .set_temp(set_temp), .state(state),
    .frame_ok(frame_ok), .frame_err(frame_err), .have_frame(have_frame), .overrun(overrun),
    .clamped(clamped), .good_count(good_count), .bad_count(bad_count), .id_out(id_out),
    .set_temp_out(set_temp_out), .state_out(state_out), .room_bcd(room_bcd),
    .bcd_ready(bcd_ready), .digit(digit), .digit_place(digit_place)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int rdy_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: frame schedule in absolute cycle numbers.
  int          cyc = 0, k = 0, free_at = 0, chk_t = -1, bcd_t = -1;
  logic        p_acc;
  logic [31:0] p_id;
  logic [15:0] p_room, p_set;
  logic [7:0]  p_st;
  logic [11:0] bcd_val;
  int          e_good, e_bad;
  logic        e_ok, e_err, e_rdy, e_have, e_over, e_clamp;
  logic [31:0] e_id;
  logic [15:0] e_set;
  logic [7:0]  e_st;
  logic [11:0] e_bcd;

  task automatic model_reset();
    k = 0; free_at = 0; chk_t = -1; bcd_t = -1;
    e_good = 0; e_bad = 0; e_ok = 0; e_err = 0; e_rdy = 0; e_have = 0; e_over = 0;
    e_clamp = 0; e_id = '0; e_set = '0; e_st = '0; e_bcd = '0;
  endtask

  task automatic model_step();
    int v;
    cyc++; k++;
    e_ok = 0; e_err = 0; e_rdy = 0;
    if (cyc == chk_t) begin
      if (p_acc) begin
        e_ok = 1;
        if (e_good < 255) e_good++;
        e_id = p_id; e_set = p_set; e_st = p_st;
        e_clamp = (p_room > 999);
        v = (p_room > 999) ? 999 : int'(p_room);
        bcd_val = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        bcd_t = cyc + 11;
      end else begin
        e_err = 1;
        if (e_bad < 255) e_bad++;
      end
    end
    if (cyc == bcd_t) begin
      e_bcd = bcd_val; e_rdy = 1; e_have = 1;
    end
    if (frame_strobe) begin
      if (cyc >= free_at) begin
        p_acc = (preamble == Pre) && (constant == Con);
        p_id = thermostat_id; p_room = room_temp; p_set = set_temp; p_st = state;
        chk_t = cyc + 1;
        free_at = p_acc ? cyc + 12 : cyc + 2;
      end else begin
        e_over = 1;
      end
    end
  endtask

  task automatic compare_all();
    int          pl;
    logic [11:0] sh;
    logic [3:0]  dexp;
    pl = (k / Hold) % 3;
    sh = e_bcd >> (4 * pl);
    dexp = e_have ? sh[3:0] : 4'hF;
    chk("frame_ok", 32'(frame_ok), 32'(e_ok));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("have_frame", 32'(have_frame), 32'(e_have));
    chk("overrun", 32'(overrun), 32'(e_over));
    chk("clamped", 32'(clamped), 32'(e_clamp));
    chk("good_count", 32'(good_count), 32'(e_good));
    chk("bad_count", 32'(bad_count), 32'(e_bad));
    chk("id_out", id_out, e_id);
    chk("set_temp_out", 32'(set_temp_out), 32'(e_set));
    chk("state_out", 32'(state_out), 32'(e_st));
    chk("room_bcd", 32'(room_bcd), 32'(e_bcd));
    chk("bcd_ready", 32'(bcd_ready), 32'(e_rdy));
    chk("digit", 32'(digit), 32'(dexp));
    chk("digit_place", 32'(digit_place), 32'(pl));
  endtask

  always @(posedge clock) begin
    if (reset_n) model_step();
    #1;
    compare_all();
    if (frame_err === 1'b1) err_seen++;
    if (bcd_ready === 1'b1) rdy_seen++;
  end

  task automatic send(input logic [31:0] pre, input logic [31:0] con, input logic [31:0] id,
                      input logic [15:0] room, input logic [15:0] set, input logic [7:0] st);
    @(negedge clock);
    preamble = pre; constant = con; thermostat_id = id;
    room_temp = room; set_temp = set; state = st; frame_strobe = 1'b1;
    @(negedge clock);
    frame_strobe = 1'b0;
    preamble = $urandom; constant = $urandom; thermostat_id = $urandom;
    room_temp = 16'($urandom); set_temp = 16'($urandom); state = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    idle(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq [3];
    logic [1:0] prev;
    logic       found;
    logic [31:0] pre_r, con_r;
    exp_seq = '{4'd5, 4'd1, 4'd2};
    model_reset();
    idle(2);
    chk("reset_digit", 32'(digit), 32'hF);
    chk("reset_good", 32'(good_count), 32'd0);
    reset_n = 1'b1;

    // Accepted frame, room 215.
    send(Pre, Con, 32'hDEAD_BEEF, 16'd215, 16'd200, 8'h03);
    @(posedge clock); #1;
    chk("t1_frame_ok", 32'(frame_ok), 32'd1);
    chk("t1_good", 32'(good_count), 32'd1);
    repeat (11) @(posedge clock);
    #1;
    chk("t1_bcd_ready", 32'(bcd_ready), 32'd1);
    chk("t1_room_bcd", 32'(room_bcd), 32'h215);
    chk("t1_id", id_out, 32'hDEAD_BEEF);
    chk("t1_set", 32'(set_temp_out), 32'd200);
    chk("t1_state", 32'(state_out), 32'h03);
    prev = digit_place;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (digit_place == 2'd0 && prev == 2'd2) begin
        found = 1'b1;
        break;
      end
      prev = digit_place;
    end
    chk("t1_display_sync", 32'(found), 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clock); #1;
      end
      chk("t1_digit_seq", 32'(digit), 32'(exp_seq[i / 4]));
    end

    // Bad preamble.
    do_reset();
    send(32'h5555_5554, Con, 32'h1234_5678, 16'd100, 16'd50, 8'h01);
    @(posedge clock); #1;
    chk("t2_frame_err", 32'(frame_err), 32'd1);
    chk("t2_bad", 32'(bad_count), 32'd1);
    chk("t2_good", 32'(good_count), 32'd0);
    idle(14);
    chk("t2_digit", 32'(digit), 32'hF);
    chk("t2_have", 32'(have_frame), 32'd0);

    // Clamp then zero.
    do_reset();
    send(Pre, Con, 32'h1, 16'd1500, 16'd1, 8'h1);
    @(posedge clock); #1;
    chk("t3_clamped", 32'(clamped), 32'd1);
    repeat (11) @(posedge clock);
    #1;
    chk("t3_bcd999", 32'(room_bcd), 32'h999);
    send(Pre, Con, 32'h2, 16'd0, 16'd2, 8'h2);
    @(posedge clock); #1;
    chk("t3_unclamped", 32'(clamped), 32'd0);
    repeat (11) @(posedge clock);
    #1;
    chk("t3_bcd000", 32'(room_bcd), 32'h000);

    // Overrun at N+5, acceptance at N+12.
    do_reset();
    send(Pre, Con, 32'hA, 16'd42, 16'd1, 8'h1);
    idle(3);
    send(Pre, Con, 32'hB, 16'd43, 16'd1, 8'h1);
    idle(5);
    send(Pre, Con, 32'hC, 16'd44, 16'd1, 8'h1);
    idle(15);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_good", 32'(good_count), 32'd2);
    chk("t4_id", id_out, 32'hC);

    // Saturation of bad_count.
    do_reset();
    err_seen = 0;
    repeat (300) begin
      send(32'h0, Con, 32'h0, 16'd0, 16'd0, 8'h0);
      idle(1);
    end
    idle(3);
    chk("t5_err_pulses", 32'(err_seen), 32'd300);
    chk("t5_bad_sat", 32'(bad_count), 32'd255);
    chk("t5_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of a conversion.
    do_reset();
    send(Pre, Con, 32'h5, 16'd215, 16'd1, 8'h1);
    idle(14);
    send(Pre, Con, 32'h6, 16'd777, 16'd1, 8'h1);
    idle(5);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_room_bcd", 32'(room_bcd), 32'h0);
    chk("t6_digit", 32'(digit), 32'hF);
    chk("t6_good", 32'(good_count), 32'd0);
    chk("t6_have", 32'(have_frame), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    idle(20);
    chk("t6_no_ready", 32'(rdy_seen), 32'd0);

    // Randomized traffic.
    do_reset();
    repeat (250) begin
      pre_r = ($urandom_range(0, 3) != 0) ? Pre : 32'($urandom);
      con_r = ($urandom_range(0, 5) != 0) ? Con : 32'($urandom_range(1, 255));
      case ($urandom_range(0, 2))
        0:       room_temp = 16'($urandom_range(0, 999));
        1:       room_temp = 16'($urandom_range(1000, 65535));
        default: room_temp = 16'($urandom_range(0, 120));
      endcase
      send(pre_r, con_r, $urandom, room_temp, 16'($urandom), 8'($urandom));
      idle($urandom_range(0, 14));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
